// File: rtl/switch_pkg.sv
// switch_pkg: parameters and buffered-entry type shared by the switch, the
// per-port readers and the tx side.
package switch_pkg;
   localparam int PORT_NUB_TOTAL = 4;
   localparam int DATA_WIDTH     = 8;
   localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
   typedef struct packed {
      logic [WIDTH_SEL-1:0]  src;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;
endpackage

// File: rtl/out_port_reader_if.sv
// out_port_reader_if: valid/ready output stream of an output-port reader.
// m_valid/m_data/m_src flow master->slave, m_ready flows slave->master.
interface out_port_reader_if import switch_pkg::*; #(
   parameter int DW = DATA_WIDTH,
   parameter int SW = WIDTH_SEL
) ();
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic [SW-1:0] m_src;
   modport master (output m_valid, m_data, m_src, input m_ready);
   modport slave (input m_valid, m_data, m_src, output m_ready);
endinterface

// File: rtl/out_port_reader_rr_pick.sv
// rr_pick: combinational cyclic priority search.
// req: request vector, ptr: highest-priority index,
// gnt_idx: first requesting index from ptr upward (mod N), any: some request.
module rr_pick import switch_pkg::*; #(
   parameter int N = PORT_NUB_TOTAL,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] gnt_idx,
   output logic         any
);
   logic [W-1:0] w_idx;
   // Walk offsets from farthest to nearest so the nearest request wins.
   always_comb begin
      gnt_idx = '0;
      w_idx = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_idx = W'((int'(ptr) + k) % N);
         if (req[w_idx]) gnt_idx = w_idx;
      end
   end
   assign any = |req;
endmodule

// File: rtl/out_port_reader.sv
// out_port_reader: round-robin read scheduler for one switch output port.
// clk/rst: clock, sync active-high reset; empty: per-source queue empty flags;
// rd_en/rd_sel: read strobe and source select; rd_data: word one cycle later;
// m: valid/ready output stream of {src, data}.
module out_port_reader import switch_pkg::*; #(
   parameter int PORT_NUB   = PORT_NUB_TOTAL,
   parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
   parameter int DEPTH      = 2,
   localparam int WIDTH_SEL = $clog2(PORT_NUB)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PORT_NUB-1:0]   empty,
   output logic                  rd_en,
   output logic [WIDTH_SEL-1:0]  rd_sel,
   input  logic [DATA_WIDTH-1:0] rd_data,
   out_port_reader_if.master     m
);
   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH + 1);
   logic [WIDTH_SEL-1:0]  r_ptr, r_infl_src, w_pick;
   logic                  r_infl, w_any, w_pop, w_credit;
   logic [OW-1:0]         r_occ;
   logic [AW-1:0]         r_wp, r_rp;
   logic [WIDTH_SEL-1:0]  r_src [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];

   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
      return a == AW'(DEPTH - 1) ? '0 : a + 1'b1;
   endfunction

   rr_pick #(.N(PORT_NUB), .W(WIDTH_SEL)) u_pick (
      .req(~empty), .ptr(r_ptr), .gnt_idx(w_pick), .any(w_any)
   );

   assign w_pop = m.m_valid & m.m_ready;
   // The in-flight word already owns a slot; a pop this cycle frees one.
   assign w_credit = (r_occ + OW'(r_infl) - OW'(w_pop)) < OW'(DEPTH);
   assign rd_en = !rst & w_credit & w_any;
   assign rd_sel = rd_en ? w_pick : '0;
   assign m.m_valid = r_occ != '0;
   assign m.m_data = m.m_valid ? r_data[r_rp] : '0;
   assign m.m_src = m.m_valid ? r_src[r_rp] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= '0;
         r_infl <= 1'b0;
         r_infl_src <= '0;
         r_occ <= '0;
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         r_infl <= rd_en;
         if (rd_en) begin
            r_ptr <= w_pick == WIDTH_SEL'(PORT_NUB - 1) ? '0 : w_pick + 1'b1;
            r_infl_src <= w_pick;
         end
         if (r_infl) begin
            r_src[r_wp] <= r_infl_src;
            r_data[r_wp] <= rd_data;
            r_wp <= nxt(r_wp);
         end
         if (w_pop) r_rp <= nxt(r_rp);
         r_occ <= r_occ + OW'(r_infl) - OW'(w_pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(r_infl && !w_pop && r_occ == OW'(DEPTH)));
endmodule
